ex_operand_stage: RTL and testbench

- ID/EX boundary stage sitting directly upstream of the execute-stage shifter and ALU.
- Registers decoded instructions in a 2-entry skid buffer with valid/ready flow control.
- Keeps buffered register operands current by snooping writeback, and applies MEM/WB forwarding at the output.
- Outputs are the shifter's A, B and shift-case select (caze), plus the destination register and PC.

---
 rtl/ex_operand_stage.sv | 183 ++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX boundary for the execute-stage shifter and ALU.
// A two-entry skid buffer (head H, skid S) holds decoded instructions.
// Stored operands track writeback, and MEM/WB bypass is applied on the way out.
// in_ready depends only on registered state, so there is no ready path from execute back to decode.
module ex_operand_stage #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [REGW-1:0] in_rs1,
   input  logic [REGW-1:0] in_rs2,
   input  logic [XLEN-1:0] in_rs1_val,
   input  logic [XLEN-1:0] in_rs2_val,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_use_imm,
   input  logic            in_is_shift,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7b5,
   input  logic [REGW-1:0] in_rd,
   input  logic            fwd_mem_valid,
   input  logic [REGW-1:0] fwd_mem_rd,
   input  logic [XLEN-1:0] fwd_mem_data,
   input  logic            fwd_wb_valid,
   input  logic [REGW-1:0] fwd_wb_rd,
   input  logic [XLEN-1:0] fwd_wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [1:0]      out_caze,
   output logic            out_is_shift,
   output logic            out_illegal,
   output logic [REGW-1:0] out_rd,
   output logic [XLEN-1:0] out_pc
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [REGW-1:0] rs1;
      logic [REGW-1:0] rs2;
      logic [XLEN-1:0] rs1_val;
      logic [XLEN-1:0] rs2_val;
      logic [XLEN-1:0] imm;
      logic            use_imm;
      logic            is_shift;
      logic [1:0]      caze;
      logic            illegal;
      logic [REGW-1:0] rd;
   } entry_t;

   localparam logic [1:0] CAZE_SLL = 2'b00;
   localparam logic [1:0] CAZE_SRL = 2'b01;
   localparam logic [1:0] CAZE_SRA = 2'b10;

   entry_t h_q, s_q, h_d, s_d;
   logic   h_vld_q, s_vld_q, h_vld_d, s_vld_d;
   entry_t h_snp, s_snp, in_ent;
   logic   accept, pop;

   // Writeback snoop: refresh a stored operand when WB writes its source register (x0 excluded).
   function automatic entry_t snoop(input entry_t e, input logic wv,
                                    input logic [REGW-1:0] wrd, input logic [XLEN-1:0] wd);
      entry_t r;
      r = e;
      if (wv && (wrd != '0) && (wrd == e.rs1)) r.rs1_val = wd;
      if (wv && (wrd != '0) && (wrd == e.rs2)) r.rs2_val = wd;
      return r;
   endfunction

   // Bypass select for one operand: MEM beats WB beats the stored value.
   function automatic logic [XLEN-1:0] fwd(input logic [REGW-1:0] rs, input logic [XLEN-1:0] stored,
                                           input logic mv, input logic [REGW-1:0] mrd,
                                           input logic [XLEN-1:0] md, input logic wv,
                                           input logic [REGW-1:0] wrd, input logic [XLEN-1:0] wd);
      logic [XLEN-1:0] r;
      r = stored;
      if (wv && (wrd != '0) && (wrd == rs)) r = wd;
      if (mv && (mrd != '0) && (mrd == rs)) r = md;
      return r;
   endfunction

   assign in_ready  = ~s_vld_q;
   assign out_valid = h_vld_q;
   assign accept    = in_valid & in_ready;
   assign pop       = h_vld_q & out_ready;

   // Build the incoming entry: decode the shift and apply the capture-cycle WB snoop.
   always_comb begin
      in_ent          = '0;
      in_ent.pc       = in_pc;
      in_ent.rs1      = in_rs1;
      in_ent.rs2      = in_rs2;
      in_ent.rs1_val  = in_rs1_val;
      in_ent.rs2_val  = in_rs2_val;
      in_ent.imm      = in_imm;
      in_ent.use_imm  = in_use_imm;
      in_ent.is_shift = in_is_shift;
      in_ent.rd       = in_rd;
      in_ent.caze     = CAZE_SLL;
      in_ent.illegal  = 1'b0;
      if (in_is_shift) begin
         if (in_funct3 == 3'b001 && !in_funct7b5) in_ent.caze = CAZE_SLL;
         else if (in_funct3 == 3'b101) in_ent.caze = in_funct7b5 ? CAZE_SRA : CAZE_SRL;
         else in_ent.illegal = 1'b1;
         // Shift amounts above 31 are not encodable for a 32-bit shifter.
         if (in_use_imm && in_imm[5]) in_ent.illegal = 1'b1;
      end
      in_ent = snoop(in_ent, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
   end

   // Snooped copies of the stored entries; invalid entries are left untouched.
   always_comb begin
      h_snp = h_vld_q ? snoop(h_q, fwd_wb_valid, fwd_wb_rd, fwd_wb_data) : h_q;
      s_snp = s_vld_q ? snoop(s_q, fwd_wb_valid, fwd_wb_rd, fwd_wb_data) : s_q;
   end

   // Skid-buffer movement: pop shifts S into H, accept fills the first free slot, flush clears valids.
   always_comb begin
      h_d     = h_snp;
      s_d     = s_snp;
      h_vld_d = h_vld_q;
      s_vld_d = s_vld_q;
      if (flush) begin
         h_vld_d = 1'b0;
         s_vld_d = 1'b0;
      end else if (pop && s_vld_q) begin
         h_d     = s_snp;
         h_vld_d = 1'b1;
         s_vld_d = accept;
         if (accept) s_d = in_ent;
      end else if (pop) begin
         h_vld_d = accept;
         if (accept) h_d = in_ent;
      end else if (accept) begin
         if (!h_vld_q) begin
            h_d     = in_ent;
            h_vld_d = 1'b1;
         end else begin
            s_d     = in_ent;
            s_vld_d = 1'b1;
         end
      end
   end

   // State register with synchronous reset of valids and payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_q     <= '0;
         s_q     <= '0;
         h_vld_q <= 1'b0;
         s_vld_q <= 1'b0;
      end else begin
         h_q     <= h_d;
         s_q     <= s_d;
         h_vld_q <= h_vld_d;
         s_vld_q <= s_vld_d;
      end
   end

   // Head outputs with MEM/WB bypass; shift immediates keep only the shamt bits.
   always_comb begin
      out_a = fwd(h_q.rs1, h_q.rs1_val, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                  fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
      if (!h_q.use_imm)
         out_b = fwd(h_q.rs2, h_q.rs2_val, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                     fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
      else if (h_q.is_shift)
         out_b = {{(XLEN-5){1'b0}}, h_q.imm[4:0]};
      else
         out_b = h_q.imm;
      out_caze     = h_q.caze;
      out_is_shift = h_q.is_shift;
      out_illegal  = h_q.illegal;
      out_rd       = h_q.rd;
      out_pc       = h_q.pc;
   end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: flow control, forwarding, snoop, flush, shift decode, reset.
module tb_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_use_imm, in_is_shift, in_funct7b5;
   logic [2:0]  in_funct3;
   logic        fwd_mem_valid, fwd_wb_valid;
   logic [4:0]  fwd_mem_rd, fwd_wb_rd;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   logic        out_valid, out_ready, out_is_shift, out_illegal;
   logic [31:0] out_a, out_b, out_pc;
   logic [1:0]  out_caze;
   logic [4:0]  out_rd;

   int n_assert = 0;
   int n_fail   = 0;

   ex_operand_stage #(.XLEN(32), .REGW(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val),
      .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_use_imm(in_use_imm),
      .in_is_shift(in_is_shift), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
      .in_rd(in_rd), .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd),
      .fwd_mem_data(fwd_mem_data), .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd),
      .fwd_wb_data(fwd_wb_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_caze(out_caze), .out_is_shift(out_is_shift),
      .out_illegal(out_illegal), .out_rd(out_rd), .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] v1,
                        input logic [4:0] rs2, input logic [31:0] v2, input logic [31:0] imm,
                        input logic ui, input logic sh, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd);
      in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs1_val = v1; in_rs2 = rs2;
      in_rs2_val = v2; in_imm = imm; in_use_imm = ui; in_is_shift = sh;
      in_funct3 = f3; in_funct7b5 = f7; in_rd = rd;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rs1_val = '0; in_rs2_val = '0; in_imm = '0;
      in_use_imm = 1'b0; in_is_shift = 1'b0; in_funct3 = '0; in_funct7b5 = 1'b0; in_rd = '0;
      fwd_mem_valid = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
      fwd_wb_valid = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_caze", out_caze, 0);

      // SRAI by 4 on 0x80000000
      drive(32'h100, 5'd3, 32'h8000_0000, 5'd0, 0, 32'd4, 1, 1, 3'b101, 1, 5'd7);
      tick();
      in_valid = 1'b0;
      chk("srai_valid", out_valid, 1);
      chk("srai_a", out_a, 32'h8000_0000);
      chk("srai_b", out_b, 32'd4);
      chk("srai_caze", out_caze, 2'b10);
      chk("srai_illegal", out_illegal, 0);
      chk("srai_rd", out_rd, 7);
      chk("srai_pc", out_pc, 32'h100);
      out_ready = 1'b1;
      tick();
      chk("srai_popped", out_valid, 0);
      out_ready = 1'b0;

      // three pushes under backpressure: only two fit
      drive(32'h200, 5'd1, 32'hA, 5'd0, 0, 0, 0, 0, 3'b000, 0, 5'd1);
      tick();
      chk("bp_ready_1", in_ready, 1);
      drive(32'h204, 5'd1, 32'hB, 5'd0, 0, 0, 0, 0, 3'b000, 0, 5'd2);
      tick();
      chk("bp_ready_2", in_ready, 0);
      drive(32'h208, 5'd1, 32'hC, 5'd0, 0, 0, 0, 0, 3'b000, 0, 5'd3);
      tick();
      in_valid = 1'b0;
      chk("bp_head_pc", out_pc, 32'h200);
      chk("bp_head_a", out_a, 32'hA);
      out_ready = 1'b1;
      tick();
      chk("bp_second_pc", out_pc, 32'h204);
      chk("bp_second_valid", out_valid, 1);
      chk("bp_ready_after", in_ready, 1);
      tick();
      chk("bp_third_dropped", out_valid, 0);

      // full throughput with out_ready held high
      drive(32'h300, 5'd1, 32'h1, 5'd0, 0, 0, 0, 0, 3'b000, 0, 5'd4);
      tick();
      chk("tp_pc0", out_pc, 32'h300);
      drive(32'h304, 5'd1, 32'h2, 5'd0, 0, 0, 0, 0, 3'b000, 0, 5'd5);
      tick();
      chk("tp_pc1", out_pc, 32'h304);
      chk("tp_valid1", out_valid, 1);
      in_valid = 1'b0;
      tick();
      chk("tp_drain", out_valid, 0);
      out_ready = 1'b0;

      // forwarding priority MEM > WB > stored, then WB snoop
      drive(32'h400, 5'd5, 32'h11, 5'd6, 32'h44, 0, 0, 0, 3'b000, 0, 5'd8);
      tick();
      in_valid = 1'b0;
      fwd_mem_valid = 1; fwd_mem_rd = 5; fwd_mem_data = 32'h22;
      fwd_wb_valid = 1;  fwd_wb_rd = 5;  fwd_wb_data = 32'h33;
      #1 chk("fwd_mem_wins", out_a, 32'h22);
      fwd_mem_valid = 0;
      #1 chk("fwd_wb", out_a, 32'h33);
      tick();
      fwd_wb_valid = 0;
      #1 chk("snoop_held", out_a, 32'h33);
      chk("fwd_b_stored", out_b, 32'h44);
      fwd_mem_valid = 1; fwd_mem_rd = 6; fwd_mem_data = 32'h55;
      #1 chk("fwd_b_mem", out_b, 32'h55);
      fwd_mem_valid = 0;

      // x0 never forwards or snoops
      out_ready = 1'b1;
      drive(32'h500, 5'd0, 32'h77, 5'd0, 0, 0, 0, 0, 3'b000, 0, 5'd9);
      tick();
      out_ready = 1'b0; in_valid = 1'b0;
      fwd_mem_valid = 1; fwd_mem_rd = 0; fwd_mem_data = 32'hFFFF;
      fwd_wb_valid = 1;  fwd_wb_rd = 0;  fwd_wb_data = 32'hFFFF;
      #1 chk("x0_no_fwd", out_a, 32'h77);
      tick();
      fwd_mem_valid = 0; fwd_wb_valid = 0;
      #1 chk("x0_no_snoop", out_a, 32'h77);

      // WB snoop in the capture cycle
      out_ready = 1'b1;
      drive(32'h600, 5'd9, 32'h1, 5'd0, 0, 0, 0, 0, 3'b000, 0, 5'd10);
      fwd_wb_valid = 1; fwd_wb_rd = 9; fwd_wb_data = 32'h99;
      tick();
      out_ready = 1'b0; in_valid = 1'b0; fwd_wb_valid = 0;
      #1 chk("capture_snoop", out_a, 32'h99);

      // flush with both entries full and a new instruction presented
      drive(32'h700, 5'd1, 0, 5'd0, 0, 0, 0, 0, 3'b000, 0, 5'd11);
      tick();
      chk("flush_full", in_ready, 0);
      flush = 1'b1;
      drive(32'h999, 5'd1, 0, 5'd0, 0, 0, 0, 0, 3'b000, 0, 5'd12);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", out_valid, 0);
      chk("flush_ready", in_ready, 1);
      tick();
      chk("flush_dropped", out_valid, 0);

      // shift decode legality
      drive(32'h800, 5'd1, 0, 5'd2, 0, 0, 0, 1, 3'b000, 0, 5'd1);
      tick();
      chk("ill_f3_illegal", out_illegal, 1);
      chk("ill_f3_caze", out_caze, 0);
      out_ready = 1'b1;
      drive(32'h804, 5'd1, 0, 5'd0, 0, 32'h20, 1, 1, 3'b001, 0, 5'd1);
      tick();
      chk("slli_big_illegal", out_illegal, 1);
      chk("slli_big_b", out_b, 0);
      drive(32'h808, 5'd1, 0, 5'd2, 32'h3, 0, 0, 1, 3'b101, 0, 5'd1);
      tick();
      chk("srl_caze", out_caze, 2'b01);
      chk("srl_legal", out_illegal, 0);
      chk("srl_b", out_b, 32'h3);
      chk("srl_is_shift", out_is_shift, 1);
      drive(32'h80C, 5'd1, 0, 5'd2, 0, 0, 0, 1, 3'b001, 1, 5'd1);
      tick();
      chk("sll_f7_illegal", out_illegal, 1);
      out_ready = 1'b0;
      drive(32'h810, 5'd1, 0, 5'd2, 0, 0, 0, 0, 3'b000, 0, 5'd1);
      tick();
      chk("pre_rst_full", in_ready, 0);

      // mid-stream reset with everything active
      rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
      drive(32'h900, 5'd1, 32'h5, 5'd0, 0, 0, 0, 1, 3'b101, 1, 5'd3);
      tick();
      rst = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_ready", in_ready, 1);
      chk("mrst_pc", out_pc, 0);
      chk("mrst_rd", out_rd, 0);
      chk("mrst_illegal", out_illegal, 0);
      chk("mrst_caze", out_caze, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
